// File: rtl/sad_block_sequencer.sv
// Fetches ROWS rows per block into the SAD engine, clears it first, drains it and captures the 16-bit SAD.
// Latency: 2 clear cycles + (2 + read latency - 1) per row + SAD_LAT + 1; no backpressure, one read outstanding.
module sad_block_sequencer #(
  parameter int ROWS    = 8,
  parameter int ADDR_W  = 8,
  parameter int SAD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [63:0]       rd_org_row,
  input  logic [63:0]       rd_ref_row,
  output logic              sad_reset,
  output logic [63:0]       org_row,
  output logic [63:0]       ref_row,
  input  logic [15:0]       sad_final_sum,
  output logic              sad_valid,
  output logic [15:0]       sad_result
);

  localparam int RW = $clog2(ROWS + 1);
  localparam int DW = (SAD_LAT < 1) ? 1 : $clog2(SAD_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    WAIT,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              clr_q, clr_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [63:0]       org_q, org_d;
  logic [63:0]       ref_q, ref_d;
  logic              sad_reset_q, sad_reset_d;
  logic [15:0]       result_q, result_d;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    base_d   = base_q;
    clr_d    = clr_q;
    drain_d  = drain_q;
    org_d    = '0;
    ref_d    = '0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          row_d   = '0;
          clr_d   = 1'b0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clr_d = 1'b1;
        if (clr_q) state_d = FETCH;
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        if (rd_valid) begin
          org_d = rd_org_row;
          ref_d = rd_ref_row;
          row_d = row_q + RW'(1);
          if (row_q == RW'(ROWS - 1)) begin
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            state_d = FETCH;
          end
        end
      end
      // Drain starts in the cycle the last row is on the bus; the sum is final SAD_LAT cycles later.
      DRAIN: begin
        if (drain_q == DW'(SAD_LAT)) begin
          result_d = sad_final_sum;
          state_d  = DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sad_reset_d = (state_d == CLEAR);
  end

  // sad_reset is registered so the engine stays cleared while reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      base_q      <= '0;
      clr_q       <= 1'b0;
      drain_q     <= '0;
      org_q       <= '0;
      ref_q       <= '0;
      sad_reset_q <= 1'b1;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      base_q      <= base_d;
      clr_q       <= clr_d;
      drain_q     <= drain_d;
      org_q       <= org_d;
      ref_q       <= ref_d;
      sad_reset_q <= sad_reset_d;
      result_q    <= result_d;
    end
  end

  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign rd_req     = (state_q == FETCH);
  assign rd_addr    = base_q + ADDR_W'(row_q);
  assign sad_valid  = (state_q == DONE);
  assign sad_reset  = sad_reset_q;
  assign org_row    = org_q;
  assign ref_row    = ref_q;
  assign sad_result = result_q;

endmodule
